rs_wakeup_array: RTL and testbench

//  Per-execution-pipe reservation-station wakeup array; the receiving end of the dispatch-to-wakeup interface.

---
 rtl/rs_wakeup_array_if.sv | 45 ++++
 rtl/rs_wakeup_array.sv | 179 +++++++++++++++++
 tb/tb_rs_wakeup_array.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_wakeup_array_if.sv
// Dispatch-to-wakeup interface of one reservation-station wakeup array.
// Bundles dispatch allocation, select request/grant, wakeup broadcast in/out
// and flush.
//   master : dispatch / select / wakeup-network side (drives dispatch, grant,
//            incoming broadcasts, flush)
//   slave  : the wakeup array (drives entry status, req, its own broadcast)
// Locations are {fu_idx, col_idx}, DPW bits wide. Pipe p's broadcast sits at
// wakeup_loc_in[p*DPW +: DPW].
interface rs_wakeup_array_if #(
  parameter int RS_ENTRIES    = 8,
  parameter int COL_IDX_WIDTH = 3,
  parameter int FU_IDX_WIDTH  = 2,
  parameter int NUM_FUS       = 4,
  parameter int LAT_WIDTH     = 4
);
  localparam int DPW = FU_IDX_WIDTH + COL_IDX_WIDTH;

  logic                     dispatch_valid;
  logic [LAT_WIDTH-1:0]     latency_in;
  logic                     src1_dp_en;
  logic [DPW-1:0]           src1_dp_loc;
  logic                     src2_dp_en;
  logic [DPW-1:0]           src2_dp_loc;
  logic                     entry_free;
  logic [COL_IDX_WIDTH-1:0] entry_index;
  logic [RS_ENTRIES-1:0]    req;
  logic [RS_ENTRIES-1:0]    grant;
  logic [NUM_FUS-1:0]       wakeup_valid_in;
  logic [NUM_FUS*DPW-1:0]   wakeup_loc_in;
  logic                     wakeup_valid_out;
  logic [DPW-1:0]           wakeup_loc_out;
  logic                     flush;

  modport master (
    output dispatch_valid, latency_in, src1_dp_en, src1_dp_loc,
           src2_dp_en, src2_dp_loc, grant, wakeup_valid_in, wakeup_loc_in, flush,
    input  entry_free, entry_index, req, wakeup_valid_out, wakeup_loc_out
  );

  modport slave (
    input  dispatch_valid, latency_in, src1_dp_en, src1_dp_loc,
           src2_dp_en, src2_dp_loc, grant, wakeup_valid_in, wakeup_loc_in, flush,
    output entry_free, entry_index, req, wakeup_valid_out, wakeup_loc_out
  );
endinterface

// File: rtl/rs_wakeup_array.sv
// Reservation-station wakeup array for one execution pipe.
// Allocates the lowest free entry on dispatch, tracks up to two producer
// dependencies per entry by RS location, requests select when both sources
// are ready, counts down the op latency after grant, then broadcasts
// {FU_ID, entry} and frees the entry.
// Ports:
//   clk    clock
//   rst    asynchronous reset, active-high
//   rs_if  dispatch/select/wakeup bundle (slave side), see rs_wakeup_array_if
//
// Per-entry state table
//   state     | meaning
//   ST_FREE   | unallocated, may be handed to dispatch
//   ST_WAIT   | allocated, waiting on pending sources and/or select grant
//   ST_ISSUED | granted, cnt counting down; cnt==0 means expired, broadcast
module rs_wakeup_array #(
  parameter int RS_ENTRIES    = 8,
  parameter int COL_IDX_WIDTH = 3,
  parameter int FU_IDX_WIDTH  = 2,
  parameter int NUM_FUS       = 4,
  parameter int FU_ID         = 0,
  parameter int LAT_WIDTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  rs_wakeup_array_if.slave  rs_if
);
  localparam int DPW = FU_IDX_WIDTH + COL_IDX_WIDTH;
  localparam logic [FU_IDX_WIDTH-1:0] FU_ID_L = FU_IDX_WIDTH'(FU_ID);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2
  } ent_state_e;

  ent_state_e            state_q [RS_ENTRIES];
  ent_state_e            state_d [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] pend1_q, pend1_d;
  logic [RS_ENTRIES-1:0] pend2_q, pend2_d;
  logic [DPW-1:0]        loc1_q  [RS_ENTRIES];
  logic [DPW-1:0]        loc1_d  [RS_ENTRIES];
  logic [DPW-1:0]        loc2_q  [RS_ENTRIES];
  logic [DPW-1:0]        loc2_d  [RS_ENTRIES];
  logic [LAT_WIDTH-1:0]  cnt_q   [RS_ENTRIES];
  logic [LAT_WIDTH-1:0]  cnt_d   [RS_ENTRIES];

  logic [RS_ENTRIES-1:0]    free_vec;
  logic [RS_ENTRIES-1:0]    expired_vec;
  logic [RS_ENTRIES-1:0]    req_vec;
  logic [COL_IDX_WIDTH-1:0] free_idx;
  logic [COL_IDX_WIDTH-1:0] exp_idx;
  logic                     any_free;
  logic                     any_expired;
  logic                     src1_hit;
  logic                     src2_hit;

  // True when any valid broadcast this cycle names location x.
  function automatic logic loc_match(input logic [DPW-1:0]         x,
                                     input logic [NUM_FUS-1:0]     v,
                                     input logic [NUM_FUS*DPW-1:0] locs);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_FUS; p++) begin
      if (v[p] && (locs[p*DPW +: DPW] == x)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Status derived from registered state only.
  always_comb begin
    free_vec    = '0;
    expired_vec = '0;
    req_vec     = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      free_vec[i]    = (state_q[i] == ST_FREE);
      expired_vec[i] = (state_q[i] == ST_ISSUED) && (cnt_q[i] == '0);
      req_vec[i]     = (state_q[i] == ST_WAIT) && !pend1_q[i] && !pend2_q[i];
    end
  end

  // Lowest-index priority encoders; descending scan so the lowest set bit wins.
  always_comb begin
    free_idx = '0;
    exp_idx  = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i])    free_idx = COL_IDX_WIDTH'(i);
      if (expired_vec[i]) exp_idx  = COL_IDX_WIDTH'(i);
    end
  end

  assign any_free    = |free_vec;
  assign any_expired = |expired_vec;

  // A source woken in the same cycle it is dispatched never becomes pending.
  assign src1_hit = loc_match(rs_if.src1_dp_loc, rs_if.wakeup_valid_in, rs_if.wakeup_loc_in);
  assign src2_hit = loc_match(rs_if.src2_dp_loc, rs_if.wakeup_valid_in, rs_if.wakeup_loc_in);

  always_comb begin
    pend1_d = pend1_q;
    pend2_d = pend2_q;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      loc1_d[i]  = loc1_q[i];
      loc2_d[i]  = loc2_q[i];
      cnt_d[i]   = cnt_q[i];
    end

    for (int i = 0; i < RS_ENTRIES; i++) begin
      unique case (state_q[i])
        ST_FREE: begin
          if (rs_if.dispatch_valid && any_free && (free_idx == COL_IDX_WIDTH'(i))) begin
            state_d[i] = ST_WAIT;
            pend1_d[i] = rs_if.src1_dp_en && !src1_hit;
            pend2_d[i] = rs_if.src2_dp_en && !src2_hit;
            loc1_d[i]  = rs_if.src1_dp_loc;
            loc2_d[i]  = rs_if.src2_dp_loc;
            cnt_d[i]   = rs_if.latency_in;
          end
        end
        ST_WAIT: begin
          if (pend1_q[i] && loc_match(loc1_q[i], rs_if.wakeup_valid_in, rs_if.wakeup_loc_in))
            pend1_d[i] = 1'b0;
          if (pend2_q[i] && loc_match(loc2_q[i], rs_if.wakeup_valid_in, rs_if.wakeup_loc_in))
            pend2_d[i] = 1'b0;
          // Grant bits on entries not requesting are ignored.
          if (req_vec[i] && rs_if.grant[i]) state_d[i] = ST_ISSUED;
        end
        ST_ISSUED: begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - LAT_WIDTH'(1);
          end else if (exp_idx == COL_IDX_WIDTH'(i)) begin
            // Only the broadcasting entry frees; other expired ones hold at 0.
            state_d[i] = ST_FREE;
          end
        end
        default: state_d[i] = ST_FREE;
      endcase

      if (rs_if.flush) begin
        state_d[i] = ST_FREE;
        pend1_d[i] = 1'b0;
        pend2_d[i] = 1'b0;
        loc1_d[i]  = '0;
        loc2_d[i]  = '0;
        cnt_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend1_q <= '0;
      pend2_q <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        loc1_q[i]  <= '0;
        loc2_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        loc1_q[i]  <= loc1_d[i];
        loc2_q[i]  <= loc2_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign rs_if.entry_free       = any_free;
  assign rs_if.entry_index      = free_idx;
  assign rs_if.req              = req_vec;
  assign rs_if.wakeup_valid_out = any_expired;
  assign rs_if.wakeup_loc_out   = any_expired ? {FU_ID_L, exp_idx} : '0;

endmodule

// File: tb/tb_rs_wakeup_array.sv
// Testbench for rs_wakeup_array: a table of per-cycle vectors for the basic
// dispatch/wakeup/grant/broadcast flow, plus hand-written sequences for
// reset, a full station, colliding expiries and flush.
module tb_rs_wakeup_array;
  logic clk;
  logic rst;

  rs_wakeup_array_if #(
    .RS_ENTRIES(8), .COL_IDX_WIDTH(3), .FU_IDX_WIDTH(2), .NUM_FUS(4), .LAT_WIDTH(4)
  ) bus ();

  rs_wakeup_array #(
    .RS_ENTRIES(8), .COL_IDX_WIDTH(3), .FU_IDX_WIDTH(2), .NUM_FUS(4),
    .FU_ID(0), .LAT_WIDTH(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rs_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        dv;
    logic [3:0]  lat;
    logic        s1en;
    logic [4:0]  s1loc;
    logic        s2en;
    logic [4:0]  s2loc;
    logic [7:0]  grant;
    logic [3:0]  wv;
    logic [19:0] wloc;
    logic        e_free;
    logic [2:0]  e_idx;
    logic [7:0]  e_req;
    logic        e_wvo;
    logic [4:0]  e_wlo;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.dispatch_valid  = 1'b0;
    bus.latency_in      = '0;
    bus.src1_dp_en      = 1'b0;
    bus.src1_dp_loc     = '0;
    bus.src2_dp_en      = 1'b0;
    bus.src2_dp_loc     = '0;
    bus.grant           = '0;
    bus.wakeup_valid_in = '0;
    bus.wakeup_loc_in   = '0;
    bus.flush           = 1'b0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] lats [7];
  logic       saw_wvo;

  initial begin
    idle_inputs();
    rst = 1'b1;
    // Row order: dv lat s1en s1loc s2en s2loc grant wv wloc | free idx req wvo wlo
    vecs[0]  = '{1'b1, 4'd2, 1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 4'b0000, 20'h00000, 1'b1, 3'd0, 8'h00, 1'b0, 5'd0};
    vecs[1]  = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b0, 5'd0,  8'h01, 4'b0000, 20'h00000, 1'b1, 3'd1, 8'h01, 1'b0, 5'd0};
    vecs[2]  = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 4'b0000, 20'h00000, 1'b1, 3'd1, 8'h00, 1'b0, 5'd0};
    vecs[3]  = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 4'b0000, 20'h00000, 1'b1, 3'd1, 8'h00, 1'b0, 5'd0};
    vecs[4]  = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 4'b0000, 20'h00000, 1'b1, 3'd1, 8'h00, 1'b1, 5'd0};
    vecs[5]  = '{1'b1, 4'd0, 1'b1, 5'd11, 1'b0, 5'd0,  8'h00, 4'b0000, 20'h00000, 1'b1, 3'd0, 8'h00, 1'b0, 5'd0};
    vecs[6]  = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 4'b0010, 20'h00140, 1'b1, 3'd1, 8'h00, 1'b0, 5'd0};
    vecs[7]  = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 4'b0010, 20'h00160, 1'b1, 3'd1, 8'h00, 1'b0, 5'd0};
    vecs[8]  = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b0, 5'd0,  8'h01, 4'b0000, 20'h00000, 1'b1, 3'd1, 8'h01, 1'b0, 5'd0};
    vecs[9]  = '{1'b1, 4'd1, 1'b1, 5'd4,  1'b1, 5'd31, 8'h00, 4'b1001, 20'hF8004, 1'b1, 3'd1, 8'h00, 1'b1, 5'd0};
    vecs[10] = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b0, 5'd0,  8'h03, 4'b0000, 20'h00000, 1'b1, 3'd0, 8'h02, 1'b0, 5'd0};
    vecs[11] = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 4'b0000, 20'h00000, 1'b1, 3'd0, 8'h00, 1'b0, 5'd0};
    vecs[12] = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 4'b0000, 20'h00000, 1'b1, 3'd0, 8'h00, 1'b1, 5'd1};
    vecs[13] = '{1'b0, 4'd0, 1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 4'b0000, 20'h00000, 1'b1, 3'd0, 8'h00, 1'b0, 5'd0};

    // Reset state, then async reset with three entries waiting.
    tick();
    tick();
    rst = 1'b0;
    chk("rst.free", 32'(bus.entry_free), 32'd1);
    chk("rst.idx",  32'(bus.entry_index), 32'd0);
    chk("rst.req",  32'(bus.req), 32'h00);
    chk("rst.wvo",  32'(bus.wakeup_valid_out), 32'd0);
    chk("rst.wlo",  32'(bus.wakeup_loc_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.dispatch_valid = 1'b1;
      bus.latency_in     = 4'd1;
      bus.src1_dp_en     = 1'b1;
      bus.src1_dp_loc    = 5'd31;
      tick();
    end
    idle_inputs();
    chk("t1.idx3", 32'(bus.entry_index), 32'd3);
    chk("t1.req0", 32'(bus.req), 32'h00);
    #3 rst = 1'b1;
    #1;
    chk("t1.async.free", 32'(bus.entry_free), 32'd1);
    chk("t1.async.idx",  32'(bus.entry_index), 32'd0);
    chk("t1.async.req",  32'(bus.req), 32'h00);
    chk("t1.async.wvo",  32'(bus.wakeup_valid_out), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Table-driven dispatch / wakeup / grant / broadcast flow.
    for (int i = 0; i < 14; i++) begin
      bus.dispatch_valid  = vecs[i].dv;
      bus.latency_in      = vecs[i].lat;
      bus.src1_dp_en      = vecs[i].s1en;
      bus.src1_dp_loc     = vecs[i].s1loc;
      bus.src2_dp_en      = vecs[i].s2en;
      bus.src2_dp_loc     = vecs[i].s2loc;
      bus.grant           = vecs[i].grant;
      bus.wakeup_valid_in = vecs[i].wv;
      bus.wakeup_loc_in   = vecs[i].wloc;
      #1;
      chk($sformatf("v%0d.free", i), 32'(bus.entry_free),       32'(vecs[i].e_free));
      chk($sformatf("v%0d.idx", i),  32'(bus.entry_index),      32'(vecs[i].e_idx));
      chk($sformatf("v%0d.req", i),  32'(bus.req),              32'(vecs[i].e_req));
      chk($sformatf("v%0d.wvo", i),  32'(bus.wakeup_valid_out), 32'(vecs[i].e_wvo));
      chk($sformatf("v%0d.wlo", i),  32'(bus.wakeup_loc_out),   32'(vecs[i].e_wlo));
      tick();
    end
    idle_inputs();

    // Fill all 8 entries, extra dispatch ignored, expire entry 5.
    for (int i = 0; i < 8; i++) begin
      bus.dispatch_valid = 1'b1;
      bus.latency_in     = 4'd3;
      tick();
    end
    chk("t5.full.free", 32'(bus.entry_free), 32'd0);
    chk("t5.full.idx",  32'(bus.entry_index), 32'd0);
    chk("t5.full.req",  32'(bus.req), 32'hFF);
    tick();
    bus.dispatch_valid = 1'b0;
    chk("t5.ignored.free", 32'(bus.entry_free), 32'd0);
    chk("t5.ignored.req",  32'(bus.req), 32'hFF);
    bus.grant = 8'h20;
    tick();
    bus.grant = 8'h00;
    chk("t5.g1.req", 32'(bus.req), 32'hDF);
    tick();
    tick();
    chk("t5.g3.wvo", 32'(bus.wakeup_valid_out), 32'd0);
    tick();
    chk("t5.g4.wvo",  32'(bus.wakeup_valid_out), 32'd1);
    chk("t5.g4.wlo",  32'(bus.wakeup_loc_out), 32'd5);
    chk("t5.g4.free", 32'(bus.entry_free), 32'd0);
    tick();
    chk("t5.g5.free", 32'(bus.entry_free), 32'd1);
    chk("t5.g5.idx",  32'(bus.entry_index), 32'd5);
    chk("t5.g5.wvo",  32'(bus.wakeup_valid_out), 32'd0);
    bus.dispatch_valid = 1'b1;
    bus.latency_in     = 4'd3;
    tick();
    bus.dispatch_valid = 1'b0;
    chk("t5.refill.free", 32'(bus.entry_free), 32'd0);
    chk("t5.refill.req",  32'(bus.req), 32'hFF);

    // Flush overrides same-cycle dispatch and grant.
    bus.flush          = 1'b1;
    bus.dispatch_valid = 1'b1;
    bus.grant          = 8'hFF;
    tick();
    idle_inputs();
    chk("flush1.free", 32'(bus.entry_free), 32'd1);
    chk("flush1.idx",  32'(bus.entry_index), 32'd0);
    chk("flush1.req",  32'(bus.req), 32'h00);
    chk("flush1.wvo",  32'(bus.wakeup_valid_out), 32'd0);

    // Entries 2 and 6 expire in the same cycle.
    lats[0] = 4'd15; lats[1] = 4'd15; lats[2] = 4'd3; lats[3] = 4'd15;
    lats[4] = 4'd15; lats[5] = 4'd15; lats[6] = 4'd2;
    for (int i = 0; i < 7; i++) begin
      bus.dispatch_valid = 1'b1;
      bus.latency_in     = lats[i];
      tick();
    end
    idle_inputs();
    chk("t6.idx7", 32'(bus.entry_index), 32'd7);
    chk("t6.req",  32'(bus.req), 32'h7F);
    bus.grant = 8'h04;
    tick();
    bus.grant = 8'h40;
    tick();
    bus.grant = 8'h00;
    chk("t6.g2.wvo", 32'(bus.wakeup_valid_out), 32'd0);
    tick();
    chk("t6.g3.wvo", 32'(bus.wakeup_valid_out), 32'd0);
    tick();
    chk("t6.g4.wvo", 32'(bus.wakeup_valid_out), 32'd1);
    chk("t6.g4.wlo", 32'(bus.wakeup_loc_out), 32'd2);
    chk("t6.g4.req", 32'(bus.req), 32'h3B);
    tick();
    chk("t6.g5.wvo", 32'(bus.wakeup_valid_out), 32'd1);
    chk("t6.g5.wlo", 32'(bus.wakeup_loc_out), 32'd6);
    chk("t6.g5.idx", 32'(bus.entry_index), 32'd2);
    tick();
    chk("t6.g6.wvo", 32'(bus.wakeup_valid_out), 32'd0);
    chk("t6.g6.idx", 32'(bus.entry_index), 32'd2);

    // Flush during a countdown: no broadcast ever follows.
    bus.grant = 8'h01;
    tick();
    bus.grant = 8'h00;
    tick();
    tick();
    chk("t6.cd.req", 32'(bus.req), 32'h3A);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush2.free", 32'(bus.entry_free), 32'd1);
    chk("flush2.idx",  32'(bus.entry_index), 32'd0);
    chk("flush2.req",  32'(bus.req), 32'h00);
    chk("flush2.wvo",  32'(bus.wakeup_valid_out), 32'd0);
    saw_wvo = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.wakeup_valid_out) saw_wvo = 1'b1;
      tick();
    end
    chk("flush2.no_bcast", 32'(saw_wvo), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
